// File: rtl/running_max_pkg.sv
// running_max_pkg: shared FSM state type for the running-max block
package running_max_pkg;
`include "running_max_defs.vh"
   typedef enum logic [1:0] {
      IDLE  = `RM_STATE_IDLE,
      ACCUM = `RM_STATE_ACCUM,
      HOLD  = `RM_STATE_HOLD
   } state_t;
endpackage

// File: rtl/running_max_defs.vh
`ifndef RUNNING_MAX_DEFS_VH
`define RUNNING_MAX_DEFS_VH
`define RM_STATE_IDLE  2'd0
`define RM_STATE_ACCUM 2'd1
`define RM_STATE_HOLD  2'd2
`endif

// File: rtl/running_max_gt_compare.sv
// gt_compare: unsigned strict greater-than, f = a > b
module gt_compare #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             f
);
   assign f = a > b;
endmodule

// File: rtl/running_max.sv
// running_max: per-frame maximum, first-occurrence index and sample count
module running_max
   import running_max_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int IDXW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [IDXW-1:0]  out_idx,
   output logic [IDXW-1:0]  out_count
);
   state_t           state, state_nx;
   logic [WIDTH-1:0] max_r;
   logic [IDXW-1:0]  idx_r, pos_r, pos_inc;
   logic             gt, acc;
   gt_compare #(.WIDTH(WIDTH)) u_gt (.a(in_data), .b(max_r), .f(gt));
   assign acc       = in_valid && in_ready;
   // pos sticks at all-ones, so idx loaded from it saturates too
   assign pos_inc   = (&pos_r) ? pos_r : pos_r + IDXW'(1);
   assign in_ready  = state != HOLD;
   assign out_valid = state == HOLD;
   assign out_max   = out_valid ? max_r : '0;
   assign out_idx   = out_valid ? idx_r : '0;
   assign out_count = out_valid ? pos_r : '0;
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = acc ? (in_last ? HOLD : ACCUM) : IDLE;
         ACCUM:   state_nx = (acc && in_last) ? HOLD : ACCUM;
         HOLD:    state_nx = out_ready ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         max_r <= '0;
         idx_r <= '0;
         pos_r <= '0;
      end else begin
         state <= state_nx;
         if (acc && state == IDLE) begin
            max_r <= in_data;
            idx_r <= '0;
            pos_r <= IDXW'(1);
         end else if (acc) begin
            pos_r <= pos_inc;
            if (gt) begin
               max_r <= in_data;
               idx_r <= pos_r;
            end
         end
      end
   end
endmodule

// File: tb/tb_running_max.sv
// tb_running_max: table-driven, hand-written and random checks of running_max
module tb_running_max;
   localparam int WIDTH = 2;
   localparam int IDXW  = 8;
   localparam int LIM   = (1 << IDXW) - 1;
   typedef struct {
      logic             v, l, r, rs, ev;
      logic [WIDTH-1:0] d, em;
      logic [IDXW-1:0]  ei, ec;
   } vec_t;
   logic             clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready, out_valid;
   logic [WIDTH-1:0] out_max;
   logic [IDXW-1:0]  out_idx, out_count;
   int               vectors = 0, miscompares = 0;
   int               q[$];
   bit               hold = 0;
   vec_t             tab[$];
   running_max #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
      .out_count(out_count)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(input logic v, input int d, input logic l, input logic r,
                               input logic rs, input logic ev, input int em, input int ei,
                               input int ec);
      vec_t t;
      t.v = v; t.d = WIDTH'(d); t.l = l; t.r = r; t.rs = rs;
      t.ev = ev; t.em = WIDTH'(em); t.ei = IDXW'(ei); t.ec = IDXW'(ec);
      return t;
   endfunction
   // reference: result recomputed from the whole accepted frame
   function automatic vec_t model_exp();
      vec_t t;
      int   mx = -1, fi = 0;
      t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (hold) begin
         foreach (q[i]) if (q[i] > mx) begin mx = q[i]; fi = i; end
         t.ev = 1;
         t.em = WIDTH'(mx);
         t.ei = IDXW'(fi > LIM ? LIM : fi);
         t.ec = IDXW'(q.size() > LIM ? LIM : q.size());
      end
      return t;
   endfunction
   task automatic apply(input string name, input vec_t t, input bit use_tab);
      vec_t e;
      @(negedge clk);
      in_valid = t.v; in_data = t.d; in_last = t.l; out_ready = t.r; rst = t.rs;
      #1;
      e = use_tab ? t : model_exp();
      vectors++;
      if (out_valid !== e.ev || in_ready !== !e.ev || out_max !== e.em ||
          out_idx !== e.ei || out_count !== e.ec) begin
         miscompares++;
         $display("FAIL %s #%0d: got v=%b rdy=%b max=%0d idx=%0d cnt=%0d, want v=%b rdy=%b max=%0d idx=%0d cnt=%0d",
                  name, vectors, out_valid, in_ready, out_max, out_idx, out_count,
                  e.ev, !e.ev, e.em, e.ei, e.ec);
      end
      @(posedge clk);
      if (t.rs) begin
         q.delete(); hold = 0;
      end else if (hold) begin
         if (t.r) begin q.delete(); hold = 0; end
      end else if (t.v) begin
         q.push_back(int'(t.d));
         if (t.l) hold = 1;
      end
   endtask
   initial begin
      // reset state
      tab.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
      // 1,3,2,0
      tab.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 3, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 1, 0, 1, 3, 1, 4));
      tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
      // ties: 2,2,2
      tab.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 2, 1, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 1, 0, 1, 2, 0, 3));
      // single sample frame
      tab.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0, 1));
      // 0,1 with backpressure; in_valid during HOLD must be ignored
      tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) tab.push_back(mk(i % 2, 3, 1, 0, 0, 1, 1, 1, 2));
      tab.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1, 2));
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      // reset mid-frame beats a simultaneous last accept
      tab.push_back(mk(1, 3, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 3, 1, 1, 1, 0, 0, 0, 0));
      tab.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 2, 1, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 1, 0, 1, 2, 1, 2));
      tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
      // 0,2,3 with idle gaps; in_last without in_valid ignored
      tab.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 1, 0, 1, 3, 2, 3));
      // reset during HOLD discards the pending result
      tab.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 0, 0, 1, 1, 2, 0, 1));
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      foreach (tab[i]) apply("table", tab[i], 1);
      // saturation: 300 samples, new max at position 280
      for (int i = 0; i < 300; i++)
         apply("sat_fill", mk(1, i == 280 ? 3 : (i >= 100 ? 1 : 0), i == 299, 1, 0, 0, 0, 0, 0), 0);
      apply("sat_hold", mk(0, 0, 0, 1, 0, 1, 3, LIM, LIM), 1);
      apply("sat_idle", mk(0, 0, 0, 1, 0, 0, 0, 0, 0), 1);
      for (int i = 0; i < 4000; i++)
         apply("random", mk($urandom_range(3) != 0, int'($urandom_range(3)),
                            $urandom_range(5) == 0, $urandom_range(2) != 0,
                            $urandom_range(199) == 0, 0, 0, 0, 0), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/running_max.md
RUNNING_MAX -- requirements
Module: running_max

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the sample width in bits.
REQ-002 The block SHALL have parameter IDXW, default 8, giving the width of the index and count fields.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input sample present.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH  unsigned sample.
- in_last  input  1  final sample of the current frame.
- out_valid  output  1  frame result available.
- out_ready  input  1  downstream accepts the result.
- out_max  output  WIDTH  largest sample in the frame.
- out_idx  output  IDXW  zero-based position of the first occurrence of out_max.
- out_count  output  IDXW  number of samples in the frame.

Function
REQ-005 A sample SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-006 The FSM SHALL have three states: IDLE (frame empty), ACCUM (frame open), HOLD (result presented).
REQ-007 IDLE SHALL drive in_ready=1 and out_valid=0; on accept it SHALL load max<=in_data, idx<=0, pos<=1, and go to HOLD if in_last is 1, else to ACCUM.
REQ-008 ACCUM SHALL drive in_ready=1 and out_valid=0; on accept, if in_data > max (unsigned, strict) it SHALL load max<=in_data and idx<=pos.
REQ-009 In ACCUM, pos SHALL increment by 1 on every accept, and the state SHALL go to HOLD if in_last is 1.
REQ-010 Ties SHALL never update max or idx, so out_idx always reports the earliest occurrence.
REQ-011 HOLD SHALL drive in_ready=0 and out_valid=1, with out_max=max, out_idx=idx and out_count=pos.
REQ-012 HOLD SHALL go to IDLE on the cycle where out_ready=1; out_valid SHALL be 0 on the following cycle.
REQ-013 out_valid SHALL rise on the first cycle after the in_last sample is accepted (latency 1), including for single-sample frames.
REQ-014 While out_valid=1 and out_ready=0, out_max, out_idx and out_count SHALL hold stable.
REQ-015 pos SHALL saturate at 2^IDXW-1; samples beyond that point still update max, and idx saturates the same way.
REQ-016 Cycles with in_valid=0 SHALL leave all state unchanged.
REQ-017 in_last asserted without in_valid SHALL be ignored.
REQ-018 Outside HOLD, out_max, out_idx and out_count SHALL be driven to 0.
REQ-019 Comparison SHALL be the only arithmetic; no signed interpretation is permitted.

Reset
REQ-020 When rst=1 at a rising edge, the state SHALL become IDLE and max, idx and pos SHALL become 0.
REQ-021 During and after reset, outputs SHALL be out_valid=0, in_ready=1 and all data outputs 0.
REQ-022 Reset asserted mid-frame (ACCUM) or during HOLD SHALL discard the partial or pending result, with no output produced for it.
REQ-023 rst SHALL take priority over any simultaneous accept or out_ready.

Structure
REQ-024 State encodings (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) SHALL be defined in shared include file running_max_defs.vh, used by both RTL and testbench.
REQ-025 The greater-than decision SHALL be made in one sub-module, gt_compare (inputs a, b [WIDTH]; output f = a>b), instantiated once.
REQ-026 The FSM, registers and output muxing SHALL reside in running_max.

Verification (WIDTH=2, IDXW=8)
REQ-027 Frame 1,3,2,0 (last on 0), out_ready=1 -> one cycle with out_valid=1, out_max=3, out_idx=1, out_count=4.
REQ-028 Frame 2,2,2 -> out_max=2, out_idx=0, out_count=3 (tie rule).
REQ-029 Single sample 3 with in_last -> out_valid the next cycle with out_max=3, out_idx=0, out_count=1.
REQ-030 Frame 0,1 with out_ready=0 for 5 cycles -> in_ready=0 and outputs stable at 1,1,2 throughout; out_ready=1 -> IDLE next cycle.
REQ-031 rst for 1 cycle after samples 3,1 (no last), then frame 1,2 -> only one result, out_max=2, out_idx=1, out_count=2.
REQ-032 Frame 0,2,3 with in_valid low 2 cycles between samples -> out_max=3, out_idx=2, out_count=3.
